fifo_wr_arbiter: RTL and testbench

//  Shares one syn_fifo write port among N requesters using round-robin bursts.

---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_select.sv | 35 +++
 rtl/fifo_wr_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter_pkg : shared FSM encoding and width helper for the arbiter
// Revision: 1.0
// ============================================================================
package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter_rr_select : combinational round-robin search from rr_ptr up
// Revision: 1.0
// ============================================================================
module fifo_wr_arbiter_rr_select #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  int w_dist;
  int w_best;

  // Lowest rotated distance from rr_ptr wins; constant indices keep the loop flat.
  always_comb begin
    found  = |req;
    idx    = '0;
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(rr_ptr)) ? (i - int'(rr_ptr)) : (i + N - int'(rr_ptr));
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        idx    = PTR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : round-robin burst arbiter sharing one FIFO write port
// Revision: 1.0
// ============================================================================
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int N         = 4,
  parameter  int BURST_LEN = 4,
  localparam int PTR_W     = ptr_width(N),
  localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata_in,
  input  logic               fifo_full,
  output logic [N-1:0]       ack,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_wdata,
  output logic               busy,
  output logic [PTR_W-1:0]   owner
);

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic [WIDTH-1:0]   words [N];
  logic               accept;
  logic               last_beat;
  logic [PTR_W-1:0]   next_ptr;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = wdata_in[i*WIDTH +: WIDTH];
  end

  fifo_wr_arbiter_rr_select #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (sel_found),
    .idx    (sel_idx)
  );

  assign accept    = (state_q == ST_GRANT) && req[owner_q] && !fifo_full;
  assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign next_ptr  = (owner_q == PTR_W'(N - 1)) ? '0 : owner_q + PTR_W'(1);

  always_comb begin
    ack = '0;
    if (accept) ack[owner_q] = 1'b1;
  end

  assign fifo_wr_en = accept;
  assign fifo_wdata = accept ? words[owner_q] : '0;
  assign busy       = (state_q == ST_GRANT);
  assign owner      = owner_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d    = ST_GRANT;
          owner_d    = sel_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // A full FIFO only stalls; withdrawal or an exhausted burst releases the port.
        if ((accept && last_beat) || !req[owner_q]) begin
          state_d  = ST_IDLE;
          owner_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_wr_arbiter : cycle-by-cycle directed vectors for fifo_wr_arbiter
// Revision: 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int N         = 4;
  localparam int BURST_LEN = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata_in;
  logic               fifo_full;
  logic [N-1:0]       ack;
  logic               fifo_wr_en;
  logic [WIDTH-1:0]   fifo_wdata;
  logic               busy;
  logic [1:0]         owner;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .WIDTH     (WIDTH),
    .N         (N),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wdata_in   (wdata_in),
    .fifo_full  (fifo_full),
    .ack        (ack),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .owner      (owner)
  );

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] ack;
    logic       wr;
    logic [7:0] wd;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_v(input int i, input logic [3:0] r, input logic f, input logic [3:0] a,
                       input logic w, input logic [7:0] d, input logic b, input logic [1:0] o);
    vecs[i] = '{req: r, full: f, ack: a, wr: w, wd: d, busy: b, owner: o};
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] a, input logic w,
                          input logic [7:0] d, input logic b, input logic [1:0] o);
    chk({tag, ".ack"},   32'(ack),        32'(a));
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(w));
    chk({tag, ".wdata"}, 32'(fifo_wdata), 32'(d));
    chk({tag, ".busy"},  32'(busy),       32'(b));
    chk({tag, ".owner"}, 32'(owner),      32'(o));
  endtask

  initial begin
    // Port words: 0->10, 1->21, 2->32, 3->43
    wdata_in  = {8'h43, 8'h32, 8'h21, 8'h10};
    rst       = 1'b1;
    req       = 4'b1111;
    fifo_full = 1'b0;

    // Lone requester 2: four beats, one idle cycle, re-grant, then withdraw.
    set_v( 0, 4'b0100, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    set_v( 1, 4'b0100, 0, 4'b0100, 1, 8'h32, 1, 2'd2);
    set_v( 2, 4'b0100, 0, 4'b0100, 1, 8'h32, 1, 2'd2);
    set_v( 3, 4'b0100, 0, 4'b0100, 1, 8'h32, 1, 2'd2);
    set_v( 4, 4'b0100, 0, 4'b0100, 1, 8'h32, 1, 2'd2);
    set_v( 5, 4'b0100, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    set_v( 6, 4'b0100, 0, 4'b0100, 1, 8'h32, 1, 2'd2);
    set_v( 7, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd2);
    set_v( 8, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    // Requester 1 withdraws after two acks; rr_ptr becomes 2 so port 3 beats port 0.
    set_v( 9, 4'b0010, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    set_v(10, 4'b0010, 0, 4'b0010, 1, 8'h21, 1, 2'd1);
    set_v(11, 4'b0010, 0, 4'b0010, 1, 8'h21, 1, 2'd1);
    set_v(12, 4'b0000, 0, 4'b0000, 0, 8'h00, 1, 2'd1);
    set_v(13, 4'b1001, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    set_v(14, 4'b1001, 0, 4'b1000, 1, 8'h43, 1, 2'd3);
    // FIFO full stalls the burst without losing beats.
    set_v(15, 4'b1001, 1, 4'b0000, 0, 8'h00, 1, 2'd3);
    set_v(16, 4'b1001, 1, 4'b0000, 0, 8'h00, 1, 2'd3);
    set_v(17, 4'b1001, 0, 4'b1000, 1, 8'h43, 1, 2'd3);
    set_v(18, 4'b1001, 0, 4'b1000, 1, 8'h43, 1, 2'd3);
    set_v(19, 4'b1001, 0, 4'b1000, 1, 8'h43, 1, 2'd3);
    set_v(20, 4'b1001, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    set_v(21, 4'b1001, 0, 4'b0001, 1, 8'h10, 1, 2'd0);
    // Withdrawal while full still releases; next search starts at 1 and finds 3.
    set_v(22, 4'b1000, 1, 4'b0000, 0, 8'h00, 1, 2'd0);
    set_v(23, 4'b1000, 0, 4'b0000, 0, 8'h00, 0, 2'd0);
    set_v(24, 4'b1000, 0, 4'b1000, 1, 8'h43, 1, 2'd3);

    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    req = 4'b0000;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      req       = vecs[i].req;
      fifo_full = vecs[i].full;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vecs[i].ack, vecs[i].wr, vecs[i].wd,
               vecs[i].busy, vecs[i].owner);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-burst (port 3 holds the grant with beats left).
    req       = 4'b1000;
    fifo_full = 1'b0;
    #1;
    chk("midburst.ack", 32'(ack), 32'(4'b1000));
    rst = 1'b1;
    #1;
    chk_outs("async_rst", 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 4'b1111;

    // All ports requesting: idle cycle then four beats each, in order 0,1,2,3.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((k % 5) == 0) begin
        chk_outs($sformatf("rot%0d", k), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      end else begin
        chk_outs($sformatf("rot%0d", k), 4'(1 << (k / 5)), 1'b1,
                 wdata_in[(k / 5) * WIDTH +: WIDTH], 1'b1, 2'(k / 5));
      end
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
